reg_dump_uart_tx: RTL



---
 rtl/reg_dump_uart_tx.sv | 105 ++++++++++
 1 files changed

// File: rtl/reg_dump_uart_tx.sv
// reg_dump_uart_tx: sends a 256-bit register snapshot as 32 UART 8N1 bytes, MSB byte first.
// Define REG_DUMP_CHECKSUM_EN to append an XOR-of-payload checksum frame before DONE.
module reg_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int NUM_BYTES = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [NUM_BYTES*8-1:0] DATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   TXD
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BYTES + 1);
  localparam int TOP = NUM_BYTES * 8 - 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES);
`else
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
`endif
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [TOP:0] shift_q, shift_d;
  logic [7:0] cur_d;
  logic txd_q, txd_d, done_q, done_d, tick;
  assign tick = cnt_q == LAST_CNT;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;
  assign acc_d = state_q == IDLE ? 8'h00 :
                 (state_q == DATA_BITS && tick && bit_q == 3'd7) ? acc_q ^ shift_q[TOP -: 8] : acc_q;
  // the frame after the last payload byte carries the accumulator instead of snapshot data
  assign cur_d = byte_d == LAST_BYTE ? acc_d : shift_d[TOP -: 8];
  always_ff @(posedge CLK) acc_q <= acc_d;
`else
  assign cur_d = shift_d[TOP -: 8];
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    byte_d = byte_q;
    shift_d = shift_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (START) begin
          state_d = START_BIT;
          shift_d = DATA;
          byte_d = '0;
        end
      end
      START_BIT: if (tick) begin
        state_d = DATA_BITS;
        bit_d = '0;
      end
      DATA_BITS: if (tick) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) begin
          state_d = STOP_BIT;
          shift_d = shift_q << 8;
        end
      end
      STOP_BIT: if (tick) begin
        if (byte_q == LAST_BYTE) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          state_d = START_BIT;
          byte_d = byte_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // line level is precomputed from next state so TXD comes straight from a flop
  assign txd_d = state_d == START_BIT ? 1'b0 : state_d == DATA_BITS ? cur_d[bit_d] : 1'b1;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      txd_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      txd_q <= txd_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge CLK) shift_q <= shift_d;
  assign BUSY = state_q != IDLE;
  assign DONE = done_q;
  assign TXD = txd_q;
endmodule
